mem_access_arbiter: RTL and testbench

//  Shares the single-port MAR/RAM memory between two requesters: port 0 = CPU control unit,

---
 rtl/sap3_mem_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/mem_access_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_access_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap3_mem_pkg.sv
// Shared types and constants for the SAP-3 memory access arbiter.
// Port 0 is the CPU control unit, port 1 is the program loader / debug port.
package sap3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } mem_arb_state_t;

  localparam int PORT_CPU      = 0;
  localparam int PORT_LDR      = 1;
  localparam int DEFAULT_DEPTH = 256;

  function automatic logic [1:0] portMask(input logic port);
    portMask = port ? 2'(1 << PORT_LDR) : 2'(1 << PORT_CPU);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter with a last-owner pointer; on a tie the port that was
// not served last wins, unless FIXED_PRIO forces port 0 to win every tie.
module rr_arbiter2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grantEn,
  output logic       gntValid,
  output logic       gntIdx
);

  logic lastOwner_q;

  // Pointer starts at port 1 so that port 0 takes the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastOwner_q <= 1'b1;
    end else if (grantEn && gntValid) begin
      lastOwner_q <= gntIdx;
    end
  end

  always_comb begin
    gntValid = |req;
    gntIdx   = 1'b0;
    case (req)
      2'b10:   gntIdx = 1'b1;
      2'b11:   gntIdx = FIXED_PRIO ? 1'b0 : ~lastOwner_q;
      default: gntIdx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Grants the single-port MAR/RAM memory to one of two requesters and sequences
// each transaction as MAR load, then RAM write or read capture, then ack.
module mem_access_arbiter
  import sap3_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              owner,
  output logic              mar_we,
  output logic              ram_we,
  output logic [ADDR_W-1:0] mem_bus,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  mem_arb_state_t    state_q, state_d;
  logic              latchWe_q, latchWe_d;
  logic [ADDR_W-1:0] latchAddr_q, latchAddr_d;
  logic [DATA_W-1:0] latchWdata_q, latchWdata_d;
  logic              owner_q, owner_d;
  logic              errFlag_q, errFlag_d;
  logic              marWe_q, marWe_d;
  logic              ramWe_q, ramWe_d;
  logic [ADDR_W-1:0] memBus_q, memBus_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              grantEn;
  logic              gntValid;
  logic              gntIdx;
  logic              take;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  assign grantEn = (state_q == IDLE);

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) uArb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grantEn (grantEn),
    .gntValid(gntValid),
    .gntIdx  (gntIdx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      latchWe_q    <= 1'b0;
      latchAddr_q  <= '0;
      latchWdata_q <= '0;
      owner_q      <= 1'b0;
      errFlag_q    <= 1'b0;
      marWe_q      <= 1'b0;
      ramWe_q      <= 1'b0;
      memBus_q     <= '0;
      ack_q        <= 2'b00;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      latchWe_q    <= latchWe_d;
      latchAddr_q  <= latchAddr_d;
      latchWdata_q <= latchWdata_d;
      owner_q      <= owner_d;
      errFlag_q    <= errFlag_d;
      marWe_q      <= marWe_d;
      ramWe_q      <= ramWe_d;
      memBus_q     <= memBus_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gntValid ? ADDR : IDLE;
      ADDR:    state_d = DATA;
      DATA:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and bus are decoded from the next state and the next latch values,
  // so they are registered yet line up with the state they belong to.
  always_comb begin
    take     = (state_q == IDLE) && gntValid;
    selAddr  = gntIdx ? addr1 : addr0;
    selWdata = gntIdx ? wdata1 : wdata0;

    latchWe_d    = take ? we[gntIdx] : latchWe_q;
    latchAddr_d  = take ? selAddr : latchAddr_q;
    latchWdata_d = take ? selWdata : latchWdata_q;
    owner_d      = take ? gntIdx : owner_q;
    errFlag_d    = take ? ({1'b0, selAddr} >= DEPTH_LIM) : errFlag_q;

    marWe_d  = 1'b0;
    ramWe_d  = 1'b0;
    memBus_d = '0;
    ack_d    = 2'b00;
    err_d    = 1'b0;
    rdata_d  = rdata_q;

    case (state_d)
      ADDR: begin
        memBus_d = latchAddr_d;
        marWe_d  = ~errFlag_d;
      end
      DATA: begin
        if (!errFlag_d && latchWe_d) begin
          ramWe_d  = 1'b1;
          memBus_d = ADDR_W'(latchWdata_d);
        end
      end
      RESP: begin
        ack_d = portMask(owner_d);
        err_d = errFlag_d;
      end
      default: ;
    endcase

    // MAR was loaded at the end of ADDR, so mem_out is valid throughout DATA.
    if ((state_q == DATA) && !errFlag_q && !latchWe_q) begin
      rdata_d = mem_out;
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign mar_we  = marWe_q;
  assign ram_we  = ramWe_q;
  assign mem_bus = memBus_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter with a behavioural MAR/RAM model,
// a vector table, hand-written corner sequences and randomized two-port traffic.
module tb_mem_access_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [7:0]  rdata;
  logic        busy;
  logic        owner;
  logic        marWe;
  logic        ramWe;
  logic [15:0] memBus;
  logic [7:0]  memOut;

  logic [1:0]  reqFp;
  logic [1:0]  ackFp;
  logic        errFp;
  logic [7:0]  rdataFp;
  logic        busyFp;
  logic        ownerFp;
  logic        marWeFp;
  logic        ramWeFp;
  logic [15:0] memBusFp;
  logic [7:0]  memOutFp;

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;

  mem_access_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .owner(owner), .mar_we(marWe), .ram_we(ramWe),
    .mem_bus(memBus), .mem_out(memOut)
  );

  mem_access_arbiter #(.FIXED_PRIO(1'b1)) dutFp (
    .clk(clk), .rst(rst), .req(reqFp), .we(2'b00), .addr0(16'h0000), .addr1(16'h0001),
    .wdata0(8'h00), .wdata1(8'h00), .ack(ackFp), .err(errFp), .rdata(rdataFp),
    .busy(busyFp), .owner(ownerFp), .mar_we(marWeFp), .ram_we(ramWeFp),
    .mem_bus(memBusFp), .mem_out(memOutFp)
  );

  assign memOutFp = 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural MAR + 256-word RAM the DUT drives.
  logic [7:0] memRam [256];
  logic [7:0] marReg;
  logic       memClear;
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) memRam[i] <= 8'h00;
    end else if (ramWe) begin
      memRam[marReg] <= memBus[7:0];
    end
    if (marWe) marReg <= memBus[7:0];
  end
  assign memOut = memRam[marReg];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w, input logic [15:0] a0,
                               input logic [15:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("strobe_excl", 32'(marWe & ramWe), 32'h0);
      checkOutput("ack_onehot", 32'($onehot0(ack)), 32'h1);
      checkOutput("fp_strobe_excl", 32'(marWeFp & ramWeFp), 32'h0);
      if (ack != 2'b00) checkOutput("ack_busy", 32'(busy), 32'h1);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  expAck;
    logic        expErr;
    logic [7:0]  expRdata;
  } vec_t;

  vec_t vecs[11];

  task automatic doVector(input vec_t v, input string tag);
    int lat;
    applyStimulus(v.req, v.we, v.a0, v.a1, v.d0, v.d1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (ack == 2'b00 && lat < 12);
    checkOutput({tag, "_ack"}, 32'(ack), 32'(v.expAck));
    checkOutput({tag, "_err"}, 32'(err), 32'(v.expErr));
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'(v.expRdata));
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    req = 2'b00;
    @(negedge clk);
  endtask

  // Reference model: RAM contents, last granted port and last read data.
  logic [7:0] refRam [256];
  int         refLast;
  logic [7:0] refRdata;

  task automatic runRound(input logic [1:0] mask, input logic [1:0] w, input logic [15:0] a0,
                          input logic [15:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    int order[$];
    int p, waitCycles, lastAck;
    logic [15:0] a;
    logic [7:0]  d;
    logic        expErr;
    if (mask == 2'b11) begin
      p = (refLast == 0) ? 1 : 0;
      order.push_back(p);
      order.push_back(1 - p);
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    applyStimulus(mask, w, a0, a1, d0, d1);
    lastAck = -1;
    while (order.size() > 0) begin
      p = order.pop_front();
      refLast = p;
      a = (p == 1) ? a1 : a0;
      d = (p == 1) ? d1 : d0;
      expErr = (a >= 16'd256);
      if (!expErr) begin
        if (w[p]) refRam[a[7:0]] = d;
        else refRdata = refRam[a[7:0]];
      end
      waitCycles = 0;
      do begin @(negedge clk); waitCycles++; end while (ack == 2'b00 && waitCycles < 16);
      checkOutput("rnd_ack", 32'(ack), 32'(1) << p);
      checkOutput("rnd_err", 32'(err), 32'(expErr));
      checkOutput("rnd_rdata", 32'(rdata), 32'(refRdata));
      if (lastAck >= 0) checkOutput("rnd_spacing", 32'(cycle - lastAck), 32'd4);
      lastAck = cycle;
      req[p] = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] randAddr();
    if ($urandom_range(0, 7) == 0) return 16'h0100 + 16'($urandom_range(0, 255));
    return 16'($urandom_range(0, 15));
  endfunction

  initial begin
    int ackSeen;
    int fpAcks;
    vec_t v;

    vecs[0]  = '{2'b01, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 8'hA5};
    vecs[1]  = '{2'b01, 2'b01, 16'h0100, 16'h0000, 8'h3C, 8'h00, 2'b01, 1'b1, 8'hA5};
    vecs[2]  = '{2'b01, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 8'h00};
    vecs[3]  = '{2'b10, 2'b10, 16'h0000, 16'h00FF, 8'h00, 8'h77, 2'b10, 1'b0, 8'h00};
    vecs[4]  = '{2'b10, 2'b00, 16'h0000, 16'h00FF, 8'h00, 8'h00, 2'b10, 1'b0, 8'h77};
    vecs[5]  = '{2'b01, 2'b00, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b1, 8'h77};
    vecs[6]  = '{2'b10, 2'b10, 16'h0000, 16'h0030, 8'h00, 8'h5C, 2'b10, 1'b0, 8'h77};
    vecs[7]  = '{2'b01, 2'b01, 16'h0000, 16'h0000, 8'h11, 8'h00, 2'b01, 1'b0, 8'h77};
    vecs[8]  = '{2'b10, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b10, 1'b0, 8'h11};
    vecs[9]  = '{2'b01, 2'b00, 16'h0100, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b1, 8'h11};
    vecs[10] = '{2'b01, 2'b00, 16'h0030, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 8'h5C};

    reqFp = 2'b00;
    memClear = 1'b1;
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset_ack", 32'(ack), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_strobes", 32'({marWe, ramWe}), 32'h0);
    checkOutput("reset_bus", 32'(memBus), 32'h0);
    checkOutput("reset_rdata_err_owner", 32'({rdata, err, owner}), 32'h0);
    memClear = 1'b0;
    rst = 1'b0;

    $display("[TB] port1 write 0x0010 <= 0xA5, cycle by cycle");
    applyStimulus(2'b10, 2'b10, 16'h0, 16'h0010, 8'h0, 8'hA5);
    @(negedge clk);
    checkOutput("w1_addr_marwe", 32'({marWe, ramWe}), 32'h2);
    checkOutput("w1_addr_bus", 32'(memBus), 32'h0010);
    checkOutput("w1_addr_busy_owner", 32'({busy, owner}), 32'h3);
    @(negedge clk);
    checkOutput("w1_data_ramwe", 32'({marWe, ramWe}), 32'h1);
    checkOutput("w1_data_bus", 32'(memBus), 32'h00A5);
    @(negedge clk);
    checkOutput("w1_resp_ack", 32'(ack), 32'h2);
    checkOutput("w1_resp_err", 32'(err), 32'h0);
    checkOutput("w1_resp_rdata", 32'(rdata), 32'h00);
    req = 2'b00;
    @(negedge clk);
    checkOutput("w1_idle_busy", 32'({busy, ack}), 32'h0);

    $display("[TB] port0 out-of-range write 0x0100");
    applyStimulus(2'b01, 2'b01, 16'h0100, 16'h0, 8'h3C, 8'h0);
    @(negedge clk);
    checkOutput("oor_addr_strobes", 32'({marWe, ramWe}), 32'h0);
    @(negedge clk);
    checkOutput("oor_data_strobes", 32'({marWe, ramWe}), 32'h0);
    @(negedge clk);
    checkOutput("oor_ack", 32'(ack), 32'h1);
    checkOutput("oor_err", 32'(err), 32'h1);
    checkOutput("oor_rdata", 32'(rdata), 32'h00);
    req = 2'b00;
    @(negedge clk);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) doVector(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] reset during DATA of a write");
    applyStimulus(2'b01, 2'b01, 16'h0020, 16'h0, 8'h99, 8'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstmid_data_ramwe", 32'(ramWe), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_strobes", 32'({marWe, ramWe}), 32'h0);
    checkOutput("rstmid_busy_ack", 32'({busy, ack}), 32'h0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    ackSeen = 0;
    repeat (6) begin @(negedge clk); if (ack != 2'b00) ackSeen++; end
    checkOutput("rstmid_no_ack", 32'(ackSeen), 32'h0);
    v = '{2'b01, 2'b00, 16'h0030, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 8'h5C};
    doVector(v, "rstmid_read30");

    $display("[TB] port0 drops req during ADDR");
    applyStimulus(2'b01, 2'b00, 16'h0010, 16'h0, 8'h0, 8'h0);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("drop_ack", 32'(ack), 32'h1);
    checkOutput("drop_rdata", 32'(rdata), 32'hA5);
    ackSeen = 0;
    repeat (6) begin @(negedge clk); if (ack != 2'b00) ackSeen++; end
    checkOutput("drop_no_reissue", 32'(ackSeen), 32'h0);
    checkOutput("drop_idle", 32'(busy), 32'h0);

    $display("[TB] randomized two-port traffic against reference model");
    rst = 1'b1;
    memClear = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    memClear = 1'b0;
    for (int i = 0; i < 256; i++) refRam[i] = 8'h00;
    refLast = 1;
    refRdata = 8'h00;
    runRound(2'b11, 2'b00, 16'h0000, 16'h0001, 8'h00, 8'h00);
    for (int n = 0; n < 40; n++) begin
      runRound(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), randAddr(), randAddr(),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("[TB] fixed-priority instance with both ports held");
    reqFp = 2'b11;
    fpAcks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ackFp != 2'b00) begin
        fpAcks++;
        checkOutput("fp_ack", 32'(ackFp), 32'h1);
        checkOutput("fp_rdata_err", 32'({rdataFp, errFp}), 32'({8'h5A, 1'b0}));
      end
    end
    checkOutput("fp_ack_count", 32'(fpAcks), 32'd7);
    reqFp = 2'b00;
    repeat (4) @(negedge clk);
    checkOutput("fp_idle", 32'({busyFp, ownerFp, memBusFp}), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
